// File: rtl/zxw_cnt_pkg.sv
// Shared definitions for the modulo-N up/down counter family.
// Holds the mode encodings and the parameter legality check used at elaboration.
package zxw_cnt_pkg;

  // Sat_EN encodings
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Up encodings
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

  // True when the width/modulus pair describes a buildable counter:
  // 2..32 bits wide, and a modulus that fits in the count register.
  function automatic bit zxw_cnt_legal(input int width, input longint modulus);
    longint max_mod;
    if ((width < 2) || (width > 32)) begin
      return 1'b0;
    end
    max_mod = longint'(1) << width;
    return (modulus >= 2) && (modulus <= max_mod);
  endfunction

endpackage

// File: rtl/zxw_cnt_next.sv
// Next-count logic for zxw_mod_updown_cnt.
// Purely combinational: given the current count, direction and mode it returns
// the value after one count step, whether that step wrapped, and whether the
// count sits at the terminal value for the selected direction.
// Arithmetic is carried one bit wider than the count so that both the
// "next value would reach MODULUS" and the "borrow out of zero" conditions
// come straight out of the adders.
module zxw_cnt_next
  import zxw_cnt_pkg::*;
#(
  parameter int     WIDTH   = 8,
  parameter longint MODULUS = 256
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up,
  input  logic             sat_en,
  output logic [WIDTH-1:0] q_next,
  output logic             wrap,
  output logic             at_term
);

  localparam longint           MOD_MAX_L = MODULUS - 1;
  localparam logic [WIDTH:0]   MOD_VAL   = MODULUS[WIDTH:0];
  localparam logic [WIDTH-1:0] MOD_MAX   = MOD_MAX_L[WIDTH-1:0];

  logic [WIDTH:0] q_ext;
  logic [WIDTH:0] inc;
  logic [WIDTH:0] dec;
  logic           at_top;
  logic           at_bottom;

  // Extended-width increment/decrement and the two limit detectors
  always_comb begin
    q_ext     = {1'b0, q};
    inc       = q_ext + 1'b1;
    dec       = q_ext - 1'b1;
    // incrementing the top value lands exactly on MODULUS
    at_top    = (inc == MOD_VAL);
    // decrementing zero borrows into the extra bit
    at_bottom = dec[WIDTH];
  end

  // One count step in the selected direction, with wrap or saturate at the limit
  always_comb begin
    q_next  = q;
    wrap    = 1'b0;
    at_term = 1'b0;
    if (up == DIR_UP) begin
      at_term = at_top;
      if (!at_top) begin
        q_next = inc[WIDTH-1:0];
      end else if (sat_en == MODE_WRAP) begin
        q_next = '0;
        wrap   = 1'b1;
      end
    end else begin
      at_term = at_bottom;
      if (!at_bottom) begin
        q_next = dec[WIDTH-1:0];
      end else if (sat_en == MODE_WRAP) begin
        q_next = MOD_MAX;
        wrap   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/zxw_mod_updown_cnt.sv
// Parametrised modulo-N up/down counter.
// Synchronous parallel load with range clamp, wrap or saturate at the limits,
// combinational terminal count for cascading (TC -> next stage Cnt_EN), and
// registered one-cycle Wrap / Ld_Err pulses.
// Optional feature macro: ZXW_CNT_CAPTURE_EN adds the Capture input and the
// Qcap snapshot register of the pre-edge count.
module zxw_mod_updown_cnt
  import zxw_cnt_pkg::*;
#(
  parameter int     WIDTH   = 8,
  parameter longint MODULUS = 256
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic [WIDTH-1:0] D,
  input  logic             LD_EN,
  input  logic             Cnt_EN,
  input  logic             Up,
  input  logic             Sat_EN,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             Wrap,
  output logic             Ld_Err
`ifdef ZXW_CNT_CAPTURE_EN
  ,
  input  logic             Capture,
  output logic [WIDTH-1:0] Qcap
`endif
);

  localparam longint           MOD_MAX_L = MODULUS - 1;
  localparam logic [WIDTH:0]   MOD_VAL   = MODULUS[WIDTH:0];
  localparam logic [WIDTH-1:0] MOD_MAX   = MOD_MAX_L[WIDTH-1:0];

  // Refuse to build a counter whose range cannot be held in WIDTH bits
  generate
    if (!zxw_cnt_legal(WIDTH, MODULUS)) begin : g_bad_params
      $error("zxw_mod_updown_cnt: illegal WIDTH/MODULUS combination");
    end
  endgenerate

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic             wrap_reg;
  logic             wrap_next;
  logic             ld_err_reg;
  logic             ld_err_next;

  logic [WIDTH-1:0] cnt_q_next;
  logic             cnt_wrap;
  logic             cnt_term;

  logic             ld_over;
  logic [WIDTH-1:0] ld_val;

  zxw_cnt_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .q       (q_reg),
    .up      (Up),
    .sat_en  (Sat_EN),
    .q_next  (cnt_q_next),
    .wrap    (cnt_wrap),
    .at_term (cnt_term)
  );

  // Load clamp: out-of-range values pin the count at the top of the range
  always_comb begin
    ld_over = ({1'b0, D} >= MOD_VAL);
    ld_val  = ld_over ? MOD_MAX : D;
  end

  // Next-state select: load beats count beats hold; pulses default low
  always_comb begin
    q_next      = q_reg;
    wrap_next   = 1'b0;
    ld_err_next = 1'b0;
    if (LD_EN) begin
      q_next      = ld_val;
      ld_err_next = ld_over;
    end else if (Cnt_EN) begin
      q_next    = cnt_q_next;
      wrap_next = cnt_wrap;
    end
  end

  // Count and pulse registers, cleared immediately by reset
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      q_reg      <= '0;
      wrap_reg   <= 1'b0;
      ld_err_reg <= 1'b0;
    end else begin
      q_reg      <= q_next;
      wrap_reg   <= wrap_next;
      ld_err_reg <= ld_err_next;
    end
  end

  // Terminal count is unregistered so a chained stage steps on the same edge
  assign TC     = Cnt_EN & cnt_term;
  assign Q      = q_reg;
  assign Wrap   = wrap_reg;
  assign Ld_Err = ld_err_reg;

`ifdef ZXW_CNT_CAPTURE_EN
  logic [WIDTH-1:0] qcap_reg;

  // Snapshot of the count as it stood before the edge, independent of load/count
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      qcap_reg <= '0;
    end else if (Capture) begin
      qcap_reg <= q_reg;
    end
  end

  assign Qcap = qcap_reg;
`endif

endmodule

// File: tb/tb_zxw_mod_updown_cnt.sv
// Bench for zxw_mod_updown_cnt (WIDTH=4, MODULUS=10).
// Two chained instances: the low stage is the main device, its TC drives the
// high stage's Cnt_EN. Each driven cycle pushes its hand-computed expectation
// into a queue; the monitor pops one entry per clock edge and compares.
module tb_zxw_mod_updown_cnt;

  typedef struct {
    logic [3:0] q;
    logic       wrap;
    logic       lderr;
    logic       tc;
    logic [3:0] hi;
    logic [3:0] qcap;
  } exp_t;

  logic       clk;
  logic       rstn;
  logic [3:0] d;
  logic       ld;
  logic       cen;
  logic       up;
  logic       sat;
  logic       cap;
  logic [3:0] q_lo;
  logic       tc_lo;
  logic       wrap_lo;
  logic       lderr_lo;
  logic [3:0] q_hi;
  logic       tc_hi;
  logic       wrap_hi;
  logic       lderr_hi;
`ifdef ZXW_CNT_CAPTURE_EN
  logic [3:0] qcap_lo;
  logic [3:0] qcap_hi;
`endif

  exp_t       exp_q[$];
  int         n_tests;
  int         n_fail;
  int         n_txn;
  logic       cap_req;
  logic [3:0] qcap_exp;

  zxw_mod_updown_cnt #(.WIDTH(4), .MODULUS(10)) dut (
    .Clock   (clk),
    .Resetn  (rstn),
    .D       (d),
    .LD_EN   (ld),
    .Cnt_EN  (cen),
    .Up      (up),
    .Sat_EN  (sat),
    .Q       (q_lo),
    .TC      (tc_lo),
    .Wrap    (wrap_lo),
    .Ld_Err  (lderr_lo)
`ifdef ZXW_CNT_CAPTURE_EN
    ,
    .Capture (cap),
    .Qcap    (qcap_lo)
`endif
  );

  zxw_mod_updown_cnt #(.WIDTH(4), .MODULUS(10)) dut_hi (
    .Clock   (clk),
    .Resetn  (rstn),
    .D       (4'd0),
    .LD_EN   (1'b0),
    .Cnt_EN  (tc_lo),
    .Up      (1'b1),
    .Sat_EN  (1'b0),
    .Q       (q_hi),
    .TC      (tc_hi),
    .Wrap    (wrap_hi),
    .Ld_Err  (lderr_hi)
`ifdef ZXW_CNT_CAPTURE_EN
    ,
    .Capture (1'b0),
    .Qcap    (qcap_hi)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue what the DUT must show after the edge
  task automatic vec(input logic i_ld, input logic [3:0] i_d, input logic i_cen,
                     input logic i_up, input logic i_sat,
                     input logic [3:0] e_q, input logic e_w, input logic e_l,
                     input logic e_tc, input logic [3:0] e_hi);
    exp_t e;
    @(negedge clk);
    ld  = i_ld;
    d   = i_d;
    cen = i_cen;
    up  = i_up;
    sat = i_sat;
    cap = cap_req;
    e.q     = e_q;
    e.wrap  = e_w;
    e.lderr = e_l;
    e.tc    = e_tc;
    e.hi    = e_hi;
    e.qcap  = qcap_exp;
    exp_q.push_back(e);
  endtask

  // Pull reset low part-way through a cycle and check that state clears at once
  task automatic reset_mid(input string tag);
    @(posedge clk);
    #3;
    ld   = 1'b0;
    cen  = 1'b0;
    rstn = 1'b0;
    #1;
    chk({tag, "_q_async"}, 32'(q_lo), 32'd0);
    chk({tag, "_hi_async"}, 32'(q_hi), 32'd0);
    chk({tag, "_wrap_async"}, 32'(wrap_lo), 32'd0);
    chk({tag, "_lderr_async"}, 32'(lderr_lo), 32'd0);
    qcap_exp = 4'd0;
`ifdef ZXW_CNT_CAPTURE_EN
    chk({tag, "_qcap_async"}, 32'(qcap_lo), 32'd0);
`endif
    @(posedge clk);
    #1;
    chk({tag, "_q_held"}, 32'(q_lo), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Monitor: TC is sampled mid-cycle with that cycle's inputs, the registered
  // outputs just after the edge that consumes them
  initial begin
    logic tc_s;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      tc_s = tc_lo;
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_txn++;
        $display("[TB] txn %0d q=%0d wrap=%0b lderr=%0b tc=%0b hi=%0d",
                 n_txn, q_lo, wrap_lo, lderr_lo, tc_s, q_hi);
        chk($sformatf("txn%0d_q", n_txn), 32'(q_lo), 32'(e.q));
        chk($sformatf("txn%0d_wrap", n_txn), 32'(wrap_lo), 32'(e.wrap));
        chk($sformatf("txn%0d_lderr", n_txn), 32'(lderr_lo), 32'(e.lderr));
        chk($sformatf("txn%0d_tc", n_txn), 32'(tc_s), 32'(e.tc));
        chk($sformatf("txn%0d_hi", n_txn), 32'(q_hi), 32'(e.hi));
`ifdef ZXW_CNT_CAPTURE_EN
        chk($sformatf("txn%0d_qcap", n_txn), 32'(qcap_lo), 32'(e.qcap));
`endif
      end
    end
  end

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    n_txn    = 0;
    cap_req  = 1'b0;
    qcap_exp = 4'd0;
    rstn = 1'b0;
    d    = 4'd0;
    ld   = 1'b0;
    cen  = 1'b0;
    up   = 1'b1;
    sat  = 1'b0;
    cap  = 1'b0;
    #3;
    chk("reset_q", 32'(q_lo), 32'd0);
    chk("reset_wrap", 32'(wrap_lo), 32'd0);
    chk("reset_lderr", 32'(lderr_lo), 32'd0);
    chk("reset_tc", 32'(tc_lo), 32'd0);
`ifdef ZXW_CNT_CAPTURE_EN
    chk("reset_qcap", 32'(qcap_lo), 32'd0);
`endif
    @(negedge clk);
    rstn = 1'b1;

    // Up count, wrap mode: 1..9, 0 (Wrap, TC while 9, high stage steps), 1, 2
    //   ld d  cen up sat   q  w  l  tc hi
    vec(0, 0, 1, 1, 0,   1, 0, 0, 0, 0);
    vec(0, 0, 1, 1, 0,   2, 0, 0, 0, 0);
    vec(0, 0, 1, 1, 0,   3, 0, 0, 0, 0);
    vec(0, 0, 1, 1, 0,   4, 0, 0, 0, 0);
    vec(0, 0, 1, 1, 0,   5, 0, 0, 0, 0);
    vec(0, 0, 1, 1, 0,   6, 0, 0, 0, 0);
    vec(0, 0, 1, 1, 0,   7, 0, 0, 0, 0);
    vec(0, 0, 1, 1, 0,   8, 0, 0, 0, 0);
    vec(0, 0, 1, 1, 0,   9, 0, 0, 0, 0);
    vec(0, 0, 1, 1, 0,   0, 1, 0, 1, 1);
    vec(0, 0, 1, 1, 0,   1, 0, 0, 0, 1);
    vec(0, 0, 1, 1, 0,   2, 0, 0, 0, 1);

    // Load 7, then count down in saturate mode: 6..0 then hold at 0, no Wrap
    vec(1, 7, 0, 0, 1,   7, 0, 0, 0, 1);
    vec(0, 0, 1, 0, 1,   6, 0, 0, 0, 1);
    vec(0, 0, 1, 0, 1,   5, 0, 0, 0, 1);
    vec(0, 0, 1, 0, 1,   4, 0, 0, 0, 1);
    vec(0, 0, 1, 0, 1,   3, 0, 0, 0, 1);
    vec(0, 0, 1, 0, 1,   2, 0, 0, 0, 1);
    vec(0, 0, 1, 0, 1,   1, 0, 0, 0, 1);
    vec(0, 0, 1, 0, 1,   0, 0, 0, 0, 1);
    vec(0, 0, 1, 0, 1,   0, 0, 0, 1, 2);
    vec(0, 0, 1, 0, 1,   0, 0, 0, 1, 3);

    // Load clamp: 12 -> 9 with Ld_Err, hold clears it, 9 is legal, 15 and 10 clamp
    vec(1, 12, 0, 1, 0,  9, 0, 1, 0, 3);
    vec(0, 0,  0, 1, 0,  9, 0, 0, 0, 3);
    vec(1, 9,  0, 1, 0,  9, 0, 0, 0, 3);
    vec(1, 15, 0, 1, 0,  9, 0, 1, 0, 3);
    vec(1, 10, 0, 1, 0,  9, 0, 1, 0, 3);

    // Load beats count; TC still follows Q/Up/Cnt_EN during the load cycle
    vec(1, 3, 1, 1, 0,   3, 0, 0, 1, 4);
    vec(1, 5, 0, 1, 0,   5, 0, 0, 0, 4);
    vec(1, 3, 1, 1, 0,   3, 0, 0, 0, 4);

    // Down count with wrap at 0, then direction and mode changes at the top
    vec(0, 0, 1, 0, 0,   2, 0, 0, 0, 4);
    vec(0, 0, 1, 0, 0,   1, 0, 0, 0, 4);
    vec(0, 0, 1, 0, 0,   0, 0, 0, 0, 4);
    vec(0, 0, 1, 0, 0,   9, 1, 0, 1, 5);
    vec(0, 0, 1, 0, 0,   8, 0, 0, 0, 5);
    vec(0, 0, 1, 1, 1,   9, 0, 0, 0, 5);
    vec(0, 0, 1, 1, 1,   9, 0, 0, 1, 6);
    vec(0, 0, 1, 1, 0,   0, 1, 0, 1, 7);
    vec(0, 0, 0, 1, 0,   0, 0, 0, 0, 7);

    // Reset mid-cycle at Q=6, then counting resumes from 0
    vec(1, 5, 0, 1, 0,   5, 0, 0, 0, 7);
    vec(0, 0, 1, 1, 0,   6, 0, 0, 0, 7);
    reset_mid("rst_q6");
    vec(0, 0, 1, 1, 0,   1, 0, 0, 0, 0);
    vec(0, 0, 1, 1, 0,   2, 0, 0, 0, 0);

    // Reset while an Ld_Err pulse is showing
    vec(1, 14, 0, 1, 0,  9, 0, 1, 0, 0);
    reset_mid("rst_lderr");

    // Cascade: 25 edges from 0 leave the pair reading 2 and 5; capture at Q=4
    for (int k = 1; k <= 25; k++) begin
      cap_req = (k == 5);
      if (k == 5) qcap_exp = 4'd4;
      vec(0, 0, 1, 1, 0, 4'(k % 10), (k % 10) == 0, 0, ((k - 1) % 10) == 9, 4'(k / 10));
    end
    cap_req = 1'b0;
    @(negedge clk);
    cen = 1'b0;
    cap = 1'b0;

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("cascade_lo", 32'(q_lo), 32'd5);
    chk("cascade_hi", 32'(q_hi), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
